vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator; successor to the fixed 640x480 controller. It produces sync, blanking, data-enable, position counters, line/frame strobes, a frame counter and a lead-ahead pixel fetch request for the framebuffer read port. It sits between the pixel clock domain and the pixel pipeline. A clock-enable input lets it run from a faster system clock divided down, for example 100 MHz with `en` asserted every 4th cycle.

## Interface
- `CW`, 11: width of the position counters; requires H_TOTAL ≤ 2^CW and V_TOTAL ≤ 2^CW.
- `H_ACTIVE`, 640: visible columns.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch. H_TOTAL = sum of the four = 800.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch. V_TOTAL = 525.
- `HS_POL`, 0: active level of `hs`.
- `VS_POL`, 0: active level of `vs`.
- `FETCH_LEAD`, 2: positions by which fetch leads display; legal range 1..H_FP+H_SYNC+H_BP-1.
- `FRAME_W`, 16: frame counter width.
- `pixel_clk`, in, 1: sole clock; every flop samples on its rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `en`, in, 1: advance enable; when low, all state and outputs hold.
- `h_count`, out, CW: current column, 0..H_TOTAL-1.
- `v_count`, out, CW: current line, 0..V_TOTAL-1.
- `hs`, out, 1: horizontal sync.
- `vs`, out, 1: vertical sync.
- `blank`, out, 1: high outside the active area.
- `de`, out, 1: equals ~`blank`.
- `line_start`, out, 1: one-cycle pulse when `h_count` becomes 0.
- `frame_start`, out, 1: one-cycle pulse when the position becomes (0,0).
- `frame_cnt`, out, FRAME_W: count of completed frame starts; wraps.
- `fetch_valid`, out, 1: the fetch position is inside the active area.
- `fetch_x`, out, CW: fetch column.
- `fetch_y`, out, CW: fetch line.

## Operation
- Display position (h,v) advances by one per `en` cycle.
- Horizontal terminal count is H_TOTAL-1, not H_TOTAL. At the terminal count h goes to 0 and v increments. At (H_TOTAL-1, V_TOTAL-1) both counters wrap to 0.
- `hs` is active when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC; otherwise it is ~HS_POL.
- `vs` is active when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC; otherwise it is ~VS_POL.
- `blank` is high unless h < H_ACTIVE and v < V_ACTIVE.
- Fetch position is a second counter pair kept exactly FETCH_LEAD positions ahead of the display position. It wraps the same way, including across line and frame boundaries.
- `fetch_valid` uses the same active-area test applied to (`fetch_x`, `fetch_y`). Every active pixel is therefore requested exactly FETCH_LEAD enabled cycles before its `de`.
- `frame_cnt` increments in the same cycle `frame_start` asserts. It wraps from 2^FRAME_W-1 to 0.

## Timing
- All outputs are registered and mutually aligned. In the cycle `h_count`=x and `v_count`=y, `hs`, `vs`, `blank`, `de` and the strobes describe (x,y) itself. There is no one-cycle skew between counters and sync.
- Reset (`rst_n`=0 at a clock edge) values:
  - h=H_TOTAL-1, v=V_TOTAL-1.
  - fetch=(FETCH_LEAD-1, 0).
  - `hs`=~HS_POL, `vs`=~VS_POL.
  - `blank`=1, `de`=0.
  - `line_start`=0, `frame_start`=0, `frame_cnt`=0.
  - `fetch_valid`=1, `fetch_x`=FETCH_LEAD-1, `fetch_y`=0.
- After reset, the first `en` cycle moves the display to (0,0). It asserts `frame_start` and `line_start` and sets `frame_cnt`=1.
- Reset mid-frame takes effect on the next edge regardless of `en`, and all of the above values apply.
- `en`=0: counters, sync levels, `frame_cnt` and fetch outputs hold. `line_start` and `frame_start` drop to 0, so a strobe lasts exactly one clock even if `en` stays high only one cycle.
- Latency from `en` sampled high to the updated outputs is 1 clock.

## Structure
- Shared package `vga_pkg` holds the 640x480@60 timing constants (the defaults above) and a derived H_TOTAL/V_TOTAL helper function.
- Sub-module `raster_counter` (params CW, H_TOTAL, V_TOTAL, reset h/v) implements the enabled, wrapping h/v counter pair.
- It is instantiated twice, once for display and once for fetch. Decode logic and strobes live in the top level.

## Test plan
- Reset, then `en`=1 continuously. First enabled cycle gives (0,0), `frame_start`=`line_start`=1, `frame_cnt`=1. The next `frame_start` comes 420000 cycles later with `frame_cnt`=2.
- Defaults: `hs` active low exactly for h=656..751, `vs` active low exactly for v=490..491. `de` is high for 640 cycles per line on lines 0..479 and never otherwise.
- `en` pulsed 1-in-4: every output changes only on enabled cycles, and strobes are exactly 1 clock wide. Total frame period is 1680000 clocks.
- FETCH_LEAD=2: `fetch_valid` rises at h=798 of line 524 with `fetch_x`=0, `fetch_y`=0. Every (x,y) with `de` was fetched exactly 2 enabled cycles earlier.
- Assert `rst_n`=0 for one cycle at (300,200) with `en`=1. Next cycle shows the reset values, followed by a clean frame from (0,0).
- Small configuration (CW=4, H 4/1/2/1, V 3/1/1/1, HS_POL=VS_POL=1, FRAME_W=2): sync is active high, totals are 8x6, and `frame_cnt` wraps 3→0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), total helper and the
// registered decode payload used by the timing generator.
package vga_pkg;

  localparam int unsigned VGA_CW       = 11;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_FRAME_W  = 16;
  localparam int unsigned VGA_LEAD     = 2;

  // Total positions along one axis: active + front porch + sync + back porch.
  function automatic int unsigned span_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic line_start;
    logic frame_start;
    logic fetch_valid;
  } timing_flags_t;

endpackage

// File: rtl/vga_timing_gen_raster_counter.sv
// Enabled h/v raster counter pair with wrap at the totals and a
// configurable reset position; also exposes the next position.
module raster_counter
  import vga_pkg::*;
#(
  parameter int unsigned CW      = VGA_CW,
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_TOTAL = 525,
  parameter int unsigned H_RST   = H_TOTAL - 1,
  parameter int unsigned V_RST   = V_TOTAL - 1
) (
  input  logic          pixel_clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] h,
  output logic [CW-1:0] v,
  output logic [CW-1:0] h_next_c,
  output logic [CW-1:0] v_next_c
);

  // Position after one enabled step; line end advances v, frame end wraps both.
  always_comb begin
    h_next_c = h + CW'(1);
    v_next_c = v;
    if (32'(h) == H_TOTAL - 1) begin
      h_next_c = '0;
      if (32'(v) == V_TOTAL - 1) v_next_c = '0;
      else                       v_next_c = v + CW'(1);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      h <= CW'(H_RST);
      v <= CW'(V_RST);
    end else if (en) begin
      h <= h_next_c;
      v <= v_next_c;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with clock enable, strobes,
// frame counter and a lead-ahead framebuffer fetch position.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CW         = VGA_CW,
  parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
  parameter int unsigned H_FP       = VGA_H_FP,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BP       = VGA_H_BP,
  parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
  parameter int unsigned V_FP       = VGA_V_FP,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BP       = VGA_V_BP,
  parameter logic        HS_POL     = 1'b0,
  parameter logic        VS_POL     = 1'b0,
  parameter int unsigned FETCH_LEAD = VGA_LEAD,
  parameter int unsigned FRAME_W    = VGA_FRAME_W
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [CW-1:0]      h_count,
  output logic [CW-1:0]      v_count,
  output logic               hs,
  output logic               vs,
  output logic               blank,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               fetch_valid,
  output logic [CW-1:0]      fetch_x,
  output logic [CW-1:0]      fetch_y
);

  localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_LO   = H_ACTIVE + H_FP;
  localparam int unsigned HS_HI   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_LO   = V_ACTIVE + V_FP;
  localparam int unsigned VS_HI   = V_ACTIVE + V_FP + V_SYNC;

  localparam timing_flags_t FLAGS_RST = '{
    hs:          ~HS_POL,
    vs:          ~VS_POL,
    blank:       1'b1,
    line_start:  1'b0,
    frame_start: 1'b0,
    fetch_valid: 1'b1
  };

  logic [CW-1:0] disp_h_next_c;
  logic [CW-1:0] disp_v_next_c;
  logic [CW-1:0] fetch_h_next_c;
  logic [CW-1:0] fetch_v_next_c;
  timing_flags_t flags_next_c;
  timing_flags_t flags_q;

  function automatic logic in_range(input logic [CW-1:0] x,
                                    input int unsigned lo,
                                    input int unsigned hi);
    return (32'(x) >= lo) && (32'(x) < hi);
  endfunction

  raster_counter #(
    .CW      (CW),
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .H_RST   (H_TOTAL - 1),
    .V_RST   (V_TOTAL - 1)
  ) u_disp (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .en        (en),
    .h         (h_count),
    .v         (v_count),
    .h_next_c  (disp_h_next_c),
    .v_next_c  (disp_v_next_c)
  );

  // Fetch counter starts FETCH_LEAD steps ahead of the display reset position.
  raster_counter #(
    .CW      (CW),
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .H_RST   (FETCH_LEAD - 1),
    .V_RST   (0)
  ) u_fetch (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .en        (en),
    .h         (fetch_x),
    .v         (fetch_y),
    .h_next_c  (fetch_h_next_c),
    .v_next_c  (fetch_v_next_c)
  );

  // Decode the upcoming position so flags register alongside the counters.
  always_comb begin
    flags_next_c             = FLAGS_RST;
    flags_next_c.hs          = in_range(disp_h_next_c, HS_LO, HS_HI) ? HS_POL : ~HS_POL;
    flags_next_c.vs          = in_range(disp_v_next_c, VS_LO, VS_HI) ? VS_POL : ~VS_POL;
    flags_next_c.blank       = !(in_range(disp_h_next_c, 0, H_ACTIVE) &&
                                 in_range(disp_v_next_c, 0, V_ACTIVE));
    flags_next_c.line_start  = (disp_h_next_c == '0);
    flags_next_c.frame_start = (disp_h_next_c == '0) && (disp_v_next_c == '0);
    flags_next_c.fetch_valid = in_range(fetch_h_next_c, 0, H_ACTIVE) &&
                               in_range(fetch_v_next_c, 0, V_ACTIVE);
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      flags_q   <= FLAGS_RST;
      frame_cnt <= '0;
    end else if (en) begin
      flags_q <= flags_next_c;
      if (flags_next_c.frame_start) frame_cnt <= frame_cnt + FRAME_W'(1);
    end else begin
      // Strobes last one clock even when en is low on the following cycle.
      flags_q.line_start  <= 1'b0;
      flags_q.frame_start <= 1'b0;
    end
  end

  assign hs          = flags_q.hs;
  assign vs          = flags_q.vs;
  assign blank       = flags_q.blank;
  assign de          = ~flags_q.blank;
  assign line_start  = flags_q.line_start;
  assign frame_start = flags_q.frame_start;
  assign fetch_valid = flags_q.fetch_valid;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance plus a tiny
// 8x6 instance, checked every cycle against a behavioural position model.
module tb_vga_timing_gen;

  logic pixel_clk = 1'b0;
  logic rst_n;
  logic en;

  logic [10:0] d_h, d_v, d_fx, d_fy;
  logic        d_hs, d_vs, d_blank, d_de, d_ls, d_fs, d_fv;
  logic [15:0] d_fc;

  logic [3:0]  s_h, s_v, s_fx, s_fy;
  logic        s_hs, s_vs, s_blank, s_de, s_ls, s_fs, s_fv;
  logic [1:0]  s_fc;

  int n_tests = 0;
  int n_fail  = 0;

  int dh, dv, dfx, dfy, dfc;
  bit dls, dfs;
  int sh, sv, sfx, sfy, sfc;
  bit sls, sfs;

  always #5 pixel_clk = ~pixel_clk;

  vga_timing_gen u_dut_def (
    .pixel_clk   (pixel_clk),
    .rst_n       (rst_n),
    .en          (en),
    .h_count     (d_h),
    .v_count     (d_v),
    .hs          (d_hs),
    .vs          (d_vs),
    .blank       (d_blank),
    .de          (d_de),
    .line_start  (d_ls),
    .frame_start (d_fs),
    .frame_cnt   (d_fc),
    .fetch_valid (d_fv),
    .fetch_x     (d_fx),
    .fetch_y     (d_fy)
  );

  vga_timing_gen #(
    .CW(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .FETCH_LEAD(2), .FRAME_W(2)
  ) u_dut_small (
    .pixel_clk   (pixel_clk),
    .rst_n       (rst_n),
    .en          (en),
    .h_count     (s_h),
    .v_count     (s_v),
    .hs          (s_hs),
    .vs          (s_vs),
    .blank       (s_blank),
    .de          (s_de),
    .line_start  (s_ls),
    .frame_start (s_fs),
    .frame_cnt   (s_fc),
    .fetch_valid (s_fv),
    .fetch_x     (s_fx),
    .fetch_y     (s_fy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int inr(input int x, input int lo, input int hi);
    return (x >= lo && x < hi) ? 1 : 0;
  endfunction

  function automatic void adv(inout int h, inout int v, input int ht, input int vt);
    h++;
    if (h == ht) begin
      h = 0;
      v++;
      if (v == vt) v = 0;
    end
  endfunction

  task automatic reset_model();
    dh = 799; dv = 524; dfx = 1; dfy = 0; dfc = 0; dls = 0; dfs = 0;
    sh = 7;   sv = 5;   sfx = 1; sfy = 0; sfc = 0; sls = 0; sfs = 0;
  endtask

  task automatic check_all();
    check("d_h",     32'(d_h),     dh);
    check("d_v",     32'(d_v),     dv);
    check("d_hs",    32'(d_hs),    1 - inr(dh, 656, 752));
    check("d_vs",    32'(d_vs),    1 - inr(dv, 490, 492));
    check("d_blank", 32'(d_blank), 1 - inr(dh, 0, 640) * inr(dv, 0, 480));
    check("d_de",    32'(d_de),    inr(dh, 0, 640) * inr(dv, 0, 480));
    check("d_ls",    32'(d_ls),    32'(dls));
    check("d_fs",    32'(d_fs),    32'(dfs));
    check("d_fc",    32'(d_fc),    dfc);
    check("d_fx",    32'(d_fx),    dfx);
    check("d_fy",    32'(d_fy),    dfy);
    check("d_fv",    32'(d_fv),    inr(dfx, 0, 640) * inr(dfy, 0, 480));
    check("s_h",     32'(s_h),     sh);
    check("s_v",     32'(s_v),     sv);
    check("s_hs",    32'(s_hs),    inr(sh, 5, 7));
    check("s_vs",    32'(s_vs),    inr(sv, 4, 5));
    check("s_blank", 32'(s_blank), 1 - inr(sh, 0, 4) * inr(sv, 0, 3));
    check("s_de",    32'(s_de),    inr(sh, 0, 4) * inr(sv, 0, 3));
    check("s_ls",    32'(s_ls),    32'(sls));
    check("s_fs",    32'(s_fs),    32'(sfs));
    check("s_fc",    32'(s_fc),    sfc);
    check("s_fx",    32'(s_fx),    sfx);
    check("s_fy",    32'(s_fy),    sfy);
    check("s_fv",    32'(s_fv),    inr(sfx, 0, 4) * inr(sfy, 0, 3));
  endtask

  // One clock with the given enable; model follows, then full comparison.
  task automatic step(input bit e);
    en = e;
    @(posedge pixel_clk);
    #1;
    if (!rst_n) begin
      reset_model();
    end else if (e) begin
      adv(dh, dv, 800, 525);
      adv(dfx, dfy, 800, 525);
      dls = (dh == 0);
      dfs = (dh == 0) && (dv == 0);
      if (dfs) dfc = (dfc + 1) % 65536;
      adv(sh, sv, 8, 6);
      adv(sfx, sfy, 8, 6);
      sls = (sh == 0);
      sfs = (sh == 0) && (sv == 0);
      if (sfs) sfc = (sfc + 1) % 4;
    end else begin
      dls = 0; dfs = 0; sls = 0; sfs = 0;
    end
    check_all();
  endtask

  initial begin
    int d_de_cnt;
    int s_de_cnt;
    d_de_cnt = 0;
    s_de_cnt = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    reset_model();

    // Reset with en low, then hand-computed reset values.
    step(1'b0);
    check("rst_d_h",  32'(d_h),  799);
    check("rst_d_v",  32'(d_v),  524);
    check("rst_d_fx", 32'(d_fx), 1);
    check("rst_d_fv", 32'(d_fv), 1);
    check("rst_d_de", 32'(d_de), 0);
    check("rst_s_h",  32'(s_h),  7);
    check("rst_s_v",  32'(s_v),  5);
    check("rst_s_hs", 32'(s_hs), 0);

    rst_n = 1'b1;
    for (int k = 1; k <= 1610; k++) begin
      step(1'b1);
      if (k <= 800) d_de_cnt += 32'(d_de);
      if (k <= 48)  s_de_cnt += 32'(s_de);
      if (k == 1) begin
        check("first_h",     32'(d_h),  0);
        check("first_v",     32'(d_v),  0);
        check("first_fs",    32'(d_fs), 1);
        check("first_ls",    32'(d_ls), 1);
        check("first_fc",    32'(d_fc), 1);
        check("first_s_fc",  32'(s_fc), 1);
      end
      if (k == 656) check("hs_655",   32'(d_hs), 1);
      if (k == 657) check("hs_656",   32'(d_hs), 0);
      if (k == 752) check("hs_751",   32'(d_hs), 0);
      if (k == 753) check("hs_752",   32'(d_hs), 1);
      if (k == 638) check("fv_x639",  32'(d_fv), 1);
      if (k == 639) check("fv_x640",  32'(d_fv), 0);
      if (k == 801) check("line1_ls", 32'(d_ls), 1);
      if (k == 801) check("line1_v",  32'(d_v),  1);
      if (k == 46)  check("s_fv_h5",  32'(s_fv), 0);
      if (k == 47) begin
        check("s_fv_rise", 32'(s_fv), 1);
        check("s_fx_rise", 32'(s_fx), 0);
        check("s_fy_rise", 32'(s_fy), 0);
      end
      if (k == 45)  check("s_vs_v5",   32'(s_vs), 0);
      if (k == 33)  check("s_vs_v4",   32'(s_vs), 1);
      if (k == 49)  check("s_frame2",  32'(s_fs), 1);
      if (k == 49)  check("s_fc2",     32'(s_fc), 2);
      if (k == 145) check("s_fc_wrap", 32'(s_fc), 0);
    end
    check("d_de_line0",  d_de_cnt, 640);
    check("s_de_frame0", s_de_cnt, 12);

    // en pulsed 1-in-4: outputs move only on enabled cycles, strobes one clock.
    for (int k = 0; k < 400; k++) step(k % 4 == 0);

    // Reset mid-frame with en high, then a clean restart from (0,0).
    rst_n = 1'b0;
    step(1'b1);
    check("mid_rst_d_h",  32'(d_h),  799);
    check("mid_rst_d_fc", 32'(d_fc), 0);
    check("mid_rst_s_h",  32'(s_h),  7);
    rst_n = 1'b1;
    step(1'b1);
    check("restart_h",  32'(d_h),  0);
    check("restart_fs", 32'(d_fs), 1);
    check("restart_fc", 32'(d_fc), 1);
    for (int k = 0; k < 60; k++) step(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
